// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-memory writer and the display-side buffer.
// Holds the writer FSM state type and the default frame-memory geometry.
package vga_pkg;

  // Frame-memory geometry defaults: 640x480 at 3 bpp, 8 pixels per 24-bit word.
  localparam int DEF_MEM_DATA_WIDTH = 24;
  localparam int DEF_MEM_ADDR_WIDTH = 16;
  localparam int DEF_PXL_WIDTH      = 3;
  localparam int DEF_PXLS_PER_WORD  = 8;
  localparam int DEF_FRAME_WORDS    = 38400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    WRITE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/vga_mem_writer.sv
// vga_mem_writer: packs a pixel stream into frame-memory words and writes
// them at consecutive addresses, wrapping at the end of the frame.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   en_i                   writer enable
//   sof_i                  start of frame: restart packing at address 0
//   pxl_i, pxl_valid_i     pixel stream in (valid/ready handshake)
//   pxl_ready_o            high while a word is being packed
//   mem_gnt_i              memory accepts the pending write this cycle
//   mem_wen_o              write request, held until granted
//   mem_addr_o, mem_data_o write address / packed word (registered)
//   frame_done_o           pulse in the cycle the last word of a frame is granted
module vga_mem_writer
  import vga_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int PXL_WIDTH      = DEF_PXL_WIDTH,
  parameter int PXLS_PER_WORD  = DEF_PXLS_PER_WORD,
  parameter int FRAME_WORDS    = DEF_FRAME_WORDS
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      en_i,
  input  logic                      sof_i,
  input  logic [PXL_WIDTH-1:0]      pxl_i,
  input  logic                      pxl_valid_i,
  output logic                      pxl_ready_o,
  input  logic                      mem_gnt_i,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] mem_data_o,
  output logic                      frame_done_o
);

  localparam int CNT_W = (PXLS_PER_WORD > 1) ? $clog2(PXLS_PER_WORD) : 1;
  localparam logic [CNT_W-1:0]          LAST_PXL  = CNT_W'(PXLS_PER_WORD - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(FRAME_WORDS - 1);

  generate
    if (PXLS_PER_WORD * PXL_WIDTH != MEM_DATA_WIDTH) begin : g_width_chk
      $error("vga_mem_writer: PXLS_PER_WORD*PXL_WIDTH must equal MEM_DATA_WIDTH");
    end
  endgenerate

  wr_state_e                 state, state_nx;
  logic [CNT_W-1:0]          cnt, cnt_nx, slot;
  logic [MEM_ADDR_WIDTH-1:0] addr, addr_nx;
  logic [MEM_DATA_WIDTH-1:0] word, word_nx;
  logic                      sof_pend, sof_pend_nx;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      word     <= '0;
      sof_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      addr     <= addr_nx;
      word     <= word_nx;
      sof_pend <= sof_pend_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    addr_nx      = addr;
    word_nx      = word;
    sof_pend_nx  = sof_pend;
    slot         = cnt;
    pxl_ready_o  = 1'b0;
    mem_wen_o    = 1'b0;
    frame_done_o = 1'b0;

    unique case (state)
      IDLE: begin
        if (en_i) begin
          state_nx    = PACK;
          cnt_nx      = '0;
          addr_nx     = '0;
          sof_pend_nx = 1'b0;
        end
      end

      PACK: begin
        pxl_ready_o = 1'b1;
        if (!en_i) begin
          // Partial word is dropped; the stale bits are overwritten on the next pack.
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          // A pixel arriving with sof_i is the first pixel of the new frame.
          if (sof_i) begin
            slot    = '0;
            cnt_nx  = '0;
            addr_nx = '0;
          end
          if (pxl_valid_i) begin
            word_nx[slot*PXL_WIDTH +: PXL_WIDTH] = pxl_i;
            if (slot == LAST_PXL) begin
              cnt_nx   = '0;
              state_nx = WRITE;
            end else begin
              cnt_nx = slot + 1'b1;
            end
          end
        end
      end

      WRITE: begin
        mem_wen_o = 1'b1;
        if (sof_i) sof_pend_nx = 1'b1;
        if (mem_gnt_i) begin
          frame_done_o = (addr == LAST_ADDR);
          // A start-of-frame seen during the write wins over the increment.
          if (sof_i || sof_pend)     addr_nx = '0;
          else if (addr == LAST_ADDR) addr_nx = '0;
          else                        addr_nx = addr + 1'b1;
          sof_pend_nx = 1'b0;
          state_nx    = en_i ? PACK : IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign mem_addr_o = addr;
  assign mem_data_o = word;

endmodule

// File: tb/tb_vga_mem_writer.sv
// Self-checking bench for vga_mem_writer: directed scenarios followed by a
// randomized phase, all checked against a transaction-level pixel/word model.
module tb_vga_mem_writer;

  // Small frame so the wrap is reachable while address 7 is still mid-frame.
  localparam int FW = 12;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        en_i = 1'b0;
  logic        sof_i = 1'b0;
  logic [2:0]  pxl_i = '0;
  logic        pxl_valid_i = 1'b0;
  logic        pxl_ready_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_wen_o;
  logic [15:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic        frame_done_o;

  vga_mem_writer #(.FRAME_WORDS(FW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .sof_i(sof_i),
    .pxl_i(pxl_i), .pxl_valid_i(pxl_valid_i), .pxl_ready_o(pxl_ready_o),
    .mem_gnt_i(mem_gnt_i), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pack8(input logic [2:0] p[8]);
    logic [23:0] w = '0;
    for (int k = 0; k < 8; k++) w = w | (24'(p[k]) << (3 * k));
    return w;
  endfunction

  // ---------------- reference model ----------------
  // Pixels accepted since the last word/frame restart, and words still owed.
  typedef struct packed { logic [15:0] a; logic [23:0] d; } wr_t;
  logic [2:0] pix_q[$];
  wr_t        exp_q[$];
  int         addr_m = 0;
  bit         pend = 0;
  bit         filled = 0;

  always @(posedge clk_i) begin
    if (!rstn_i) begin
      pix_q.delete(); exp_q.delete();
      addr_m = 0; pend = 0; filled = 0;
    end else begin
      if (filled) chk("wr_latency", 64'(mem_wen_o), 64'd1);
      filled = 0;
      if (mem_wen_o) begin
        chk("rdy_in_write", 64'(pxl_ready_o), 64'd0);
        if (exp_q.size() == 0) chk("unexpected_wen", 64'd1, 64'd0);
        else begin
          chk("wr_addr", 64'(mem_addr_o), 64'(exp_q[0].a));
          chk("wr_data", 64'(mem_data_o), 64'(exp_q[0].d));
        end
        if (mem_gnt_i) begin
          chk("frame_done", 64'(frame_done_o), 64'(addr_m == FW - 1));
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          addr_m = (sof_i || pend) ? 0 : (addr_m + 1) % FW;
          pend = 0;
        end else begin
          chk("fd_quiet", 64'(frame_done_o), 64'd0);
          if (sof_i) pend = 1;
        end
      end else begin
        chk("fd_quiet", 64'(frame_done_o), 64'd0);
        if (pxl_ready_o) begin
          if (!en_i) pix_q.delete();
          else begin
            if (sof_i) begin pix_q.delete(); addr_m = 0; end
            if (pxl_valid_i) pix_q.push_back(pxl_i);
            if (pix_q.size() == 8) begin
              logic [2:0] p[8];
              for (int k = 0; k < 8; k++) p[k] = pix_q[k];
              exp_q.push_back('{a: 16'(addr_m), d: pack8(p)});
              pix_q.delete();
              filled = 1;
            end
          end
        end else begin
          // Writer idle: the next enable starts a fresh frame at address 0.
          pix_q.delete(); addr_m = 0; pend = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; offers one pixel once ready and returns at the negedge after acceptance.
  task automatic put(input logic [2:0] v, input logic s);
    int n = 0;
    while (!pxl_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) begin chk("put_timeout", 64'd1, 64'd0); return; end
    pxl_valid_i = 1'b1; pxl_i = v; sof_i = s;
    @(negedge clk_i);
    pxl_valid_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic put_word(output logic [23:0] w);
    logic [2:0] p[8];
    for (int k = 0; k < 8; k++) begin
      p[k] = 3'($urandom_range(0, 7));
      put(p[k], 1'b0);
    end
    w = pack8(p);
  endtask

  logic [23:0] w, d0;
  logic [15:0] a0;
  logic [2:0]  p8[8];

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 64'(pxl_ready_o), 64'd0);
    chk("rst_wen",   64'(mem_wen_o),   64'd0);
    chk("rst_addr",  64'(mem_addr_o),  64'd0);
    chk("rst_data",  64'(mem_data_o),  64'd0);
    chk("rst_fd",    64'(frame_done_o), 64'd0);

    rstn_i = 1'b1; en_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk_i);

    // Pixels 0..7 -> 0xFAC688 at address 0, one cycle after the 8th accept.
    for (int i = 0; i < 8; i++) put(3'(i), 1'b0);
    chk("first_wen",  64'(mem_wen_o),  64'd1);
    chk("first_addr", 64'(mem_addr_o), 64'd0);
    chk("first_data", 64'(mem_data_o), 64'hFAC688);
    @(negedge clk_i);
    chk("first_done", 64'(mem_wen_o), 64'd0);

    // Grant withheld for 5 cycles: request and payload held, no pixels taken.
    mem_gnt_i = 1'b0;
    put_word(w);
    a0 = mem_addr_o; d0 = mem_data_o;
    chk("stall_addr", 64'(a0), 64'd1);
    chk("stall_data", 64'(d0), 64'(w));
    for (int i = 0; i < 5; i++) begin
      chk("stall_wen",   64'(mem_wen_o),   64'd1);
      chk("stall_addr_hold", 64'(mem_addr_o), 64'(a0));
      chk("stall_data_hold", 64'(mem_data_o), 64'(d0));
      chk("stall_ready", 64'(pxl_ready_o), 64'd0);
      @(negedge clk_i);
    end
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("stall_release", 64'(mem_wen_o), 64'd0);

    // Addresses 2..6, then sof during the addr-7 write.
    for (int i = 2; i < 7; i++) put_word(w);
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    put_word(w);
    chk("sofw_addr7", 64'(mem_addr_o), 64'd7);
    sof_i = 1'b1;
    @(negedge clk_i);
    sof_i = 1'b0; mem_gnt_i = 1'b1;
    #1 chk("sofw_fd", 64'(frame_done_o), 64'd0);
    @(negedge clk_i);
    put_word(w);
    chk("sofw_next_addr", 64'(mem_addr_o), 64'd0);
    @(negedge clk_i);

    // Full frame: addresses 1..FW-1 after the addr-0 word, frame_done on the last grant.
    for (int i = 1; i < FW; i++) begin
      mem_gnt_i = 1'b0;
      put_word(w);
      chk("frame_addr", 64'(mem_addr_o), 64'(i));
      mem_gnt_i = 1'b1;
      #1 chk("frame_fd", 64'(frame_done_o), 64'(i == FW - 1));
      @(negedge clk_i);
    end
    put_word(w);
    chk("wrap_addr", 64'(mem_addr_o), 64'd0);
    @(negedge clk_i);

    // sof after 3 pixels, carrying pixel 5: earlier pixels discarded.
    for (int i = 0; i < 3; i++) put(3'($urandom_range(0, 7)), 1'b0);
    p8[0] = 3'd5;
    put(3'd5, 1'b1);
    for (int k = 1; k < 8; k++) begin
      p8[k] = 3'($urandom_range(0, 7));
      put(p8[k], 1'b0);
    end
    chk("sofp_addr", 64'(mem_addr_o), 64'd0);
    chk("sofp_pix0", 64'(mem_data_o[2:0]), 64'd5);
    chk("sofp_data", 64'(mem_data_o), 64'(pack8(p8)));
    @(negedge clk_i);

    // Reset in the middle of a stalled write.
    mem_gnt_i = 1'b0;
    put_word(w);
    @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_wen",   64'(mem_wen_o),    64'd0);
    chk("arst_ready", 64'(pxl_ready_o),  64'd0);
    chk("arst_addr",  64'(mem_addr_o),   64'd0);
    chk("arst_data",  64'(mem_data_o),   64'd0);
    chk("arst_fd",    64'(frame_done_o), 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 7; i++) put(3'($urandom_range(0, 7)), 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("arst_no_wen", 64'(mem_wen_o), 64'd0);
      @(negedge clk_i);
    end
    put(3'($urandom_range(0, 7)), 1'b0);
    chk("arst_new_wen",  64'(mem_wen_o),  64'd1);
    chk("arst_new_addr", 64'(mem_addr_o), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      pxl_valid_i = ($urandom_range(0, 9) < 7);
      pxl_i       = 3'($urandom_range(0, 7));
      sof_i       = ($urandom_range(0, 99) < 3);
      en_i        = ($urandom_range(0, 99) < 97);
      mem_gnt_i   = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk_i);
    pxl_valid_i = 1'b0; sof_i = 1'b0; mem_gnt_i = 1'b1; en_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("drain_wen", 64'(mem_wen_o), 64'd0);
    chk("drain_owed", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
